// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   clr_state_e : state encoding of the post-reset clear sequencer
//   addr_width  : address bits needed to index a given number of entries
package regfile_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } clr_state_e;

  // ceil(log2(n)), with a minimum of 1 so a 2-entry file still has an address bit.
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_mp_wr_sel.sv
// Write-port resolver for regfile_mp.
// For every register address, reports whether any enabled write port targets it and
// which data wins. Ports are scanned in ascending order so the highest-indexed port
// overwrites lower ones, giving "highest port wins" on collisions.
//   wr_en_i   : per-port write enable (already qualified by the caller)
//   wr_addr_i : per-port write address
//   wr_data_i : per-port write data
//   hit_o     : per-address "some port writes here this cycle"
//   data_o    : per-address winning write data (zero when no hit)
module regfile_mp_wr_sel
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WIDTH    = 288,
  parameter int unsigned WR_PORTS = 2,
  localparam int unsigned AW      = addr_width(DEPTH)
) (
  input  logic [WR_PORTS-1:0]            wr_en_i,
  input  logic [WR_PORTS-1:0][AW-1:0]    wr_addr_i,
  input  logic [WR_PORTS-1:0][WIDTH-1:0] wr_data_i,
  output logic [DEPTH-1:0]               hit_o,
  output logic [DEPTH-1:0][WIDTH-1:0]    data_o
);

  always_comb begin
    hit_o  = '0;
    data_o = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w] == AW'(a))) begin
          hit_o[a]  = 1'b1;
          data_o[a] = wr_data_i[w];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads and a post-reset clear sequencer.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-edge writes to reads.
//   clk       : single clock, rising edge
//   reset     : synchronous active-low reset
//   freeze    : stall; blocks writes and holds rd_data
//   rd_addr   : per-read-port address
//   rd_data   : per-read-port registered data (one-cycle latency)
//   wr_en     : per-write-port enable
//   wr_addr   : per-write-port address
//   wr_data   : per-write-port data
//   init_busy : high while the array is being cleared after reset
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned WIDTH    = 288,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 2,
  localparam int unsigned AW      = addr_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           freeze,
  input  logic [RD_PORTS-1:0][AW-1:0]    rd_addr,
  output logic [RD_PORTS-1:0][WIDTH-1:0] rd_data,
  input  logic [WR_PORTS-1:0]            wr_en,
  input  logic [WR_PORTS-1:0][AW-1:0]    wr_addr,
  input  logic [WR_PORTS-1:0][WIDTH-1:0] wr_data,
  output logic                           init_busy
);

  clr_state_e                    state_q;
  logic [AW-1:0]                 clr_idx_q;
  logic                          busy_q;
  logic [RD_PORTS-1:0][WIDTH-1:0] rd_data_q;
  logic [RD_PORTS-1:0][WIDTH-1:0] rd_val;

  // No reset term: the array is zeroed only by the clear sequencer.
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Writes commit only in IDLE, unfrozen, and not on a reset edge.
  logic                        wr_ok;
  logic [WR_PORTS-1:0]         wr_en_q;
  logic [DEPTH-1:0]            wr_hit;
  logic [DEPTH-1:0][WIDTH-1:0] wr_win;

  assign wr_ok   = reset && !freeze && (state_q == StIdle);
  assign wr_en_q = wr_en & {WR_PORTS{wr_ok}};

  regfile_mp_wr_sel #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .WR_PORTS (WR_PORTS)
  ) u_wr_sel (
    .wr_en_i   (wr_en_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .hit_o     (wr_hit),
    .data_o    (wr_win)
  );

  // Array update: the clear sequencer owns the write port while in CLEAR.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (wr_hit[a]) begin
          mem_q[a] <= wr_win[a];
        end
      end
    end
  end

  // Next read value per port; with bypass, a write committing this edge is forwarded.
  always_comb begin
    rd_val = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_hit[rd_addr[p]]) begin
        rd_val[p] = wr_win[rd_addr[p]];
      end else begin
        rd_val[p] = mem_q[rd_addr[p]];
      end
`else
      rd_val[p] = mem_q[rd_addr[p]];
`endif
    end
  end

  // Clear sequencer and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
      rd_data_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          // freeze does not stall the clear; reads stay forced to zero.
          rd_data_q <= '0;
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (!freeze) begin
            rd_data_q <= rd_val;
          end
        end
        default: begin
          state_q   <= StClear;
          clr_idx_q <= '0;
          busy_q    <= 1'b1;
          rd_data_q <= '0;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign init_busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned WIDTH    = 288;
  localparam int unsigned RD_PORTS = 2;
  localparam int unsigned WR_PORTS = 2;
  localparam int unsigned AW       = 4;

  logic                           clk;
  logic                           reset;
  logic                           freeze;
  logic [RD_PORTS-1:0][AW-1:0]    rd_addr;
  logic [RD_PORTS-1:0][WIDTH-1:0] rd_data;
  logic [WR_PORTS-1:0]            wr_en;
  logic [WR_PORTS-1:0][AW-1:0]    wr_addr;
  logic [WR_PORTS-1:0][WIDTH-1:0] wr_data;
  logic                           init_busy;

  int checks;
  int failures;
  int n;
  logic [WIDTH-1:0] wide;
  logic [WIDTH-1:0] exp8;

  regfile_mp #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WR_PORTS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .freeze    (freeze),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Count edges until init_busy drops, bounded.
  task automatic count_clear(output int edges);
    edges = 0;
    while (init_busy === 1'b1 && edges < 40) begin
      step();
      edges++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    freeze   = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;

    // Reset edge
    step();
    check("reset_busy", WIDTH'(init_busy), WIDTH'(1));
    check("reset_rd0", rd_data[0], '0);
    check("reset_rd1", rd_data[1], '0);

    // Clear takes exactly DEPTH edges after release
    reset = 1'b1;
    step();
    check("clear_rd0_forced", rd_data[0], '0);
    n = 1;
    begin
      int more;
      count_clear(more);
      n = n + more;
    end
    check("clear_edges", WIDTH'(n), WIDTH'(16));
    check("idle_busy", WIDTH'(init_busy), WIDTH'(0));

    // Every entry reads zero
    for (int i = 0; i < DEPTH; i += 2) begin
      rd_addr[0] = AW'(i);
      rd_addr[1] = AW'(i + 1);
      step();
      check("zero_rd0", rd_data[0], '0);
      check("zero_rd1", rd_data[1], '0);
    end

    // Port 0 writes 2 to addr 15; read 14 and 15
    wr_en      = 2'b01;
    wr_addr[0] = 4'd15;
    wr_data[0] = WIDTH'(2);
    step();
    wr_en      = 2'b00;
    rd_addr[0] = 4'd14;
    rd_addr[1] = 4'd15;
    step();
    check("wr15_rd14", rd_data[0], WIDTH'(0));
    check("wr15_rd15", rd_data[1], WIDTH'(2));

    // Collision on addr 5: port 1 wins; both read ports see it
    wr_en      = 2'b11;
    wr_addr[0] = 4'd5;
    wr_data[0] = WIDTH'(7);
    wr_addr[1] = 4'd5;
    wr_data[1] = WIDTH'(9);
    step();
    wr_en      = 2'b00;
    rd_addr[0] = 4'd5;
    rd_addr[1] = 4'd5;
    step();
    check("collide_rd0", rd_data[0], WIDTH'(9));
    check("collide_rd1", rd_data[1], WIDTH'(9));

    // Freeze: write to addr 3 blocked, read outputs held despite new addresses
    freeze     = 1'b1;
    wr_en      = 2'b01;
    wr_addr[0] = 4'd3;
    wr_data[0] = WIDTH'(4);
    rd_addr[0] = 4'd3;
    rd_addr[1] = 4'd15;
    step();
    check("freeze_hold0", rd_data[0], WIDTH'(9));
    check("freeze_hold1", rd_data[1], WIDTH'(9));
    step();
    check("freeze_hold0b", rd_data[0], WIDTH'(9));
    freeze = 1'b0;
    wr_en  = 2'b00;
    step();
    check("freeze_addr3", rd_data[0], WIDTH'(0));
    check("freeze_addr15", rd_data[1], WIDTH'(2));

    // Distinct addresses in one cycle both commit; wide pattern exercises all bits
    wide       = {9{32'hDEAD_BEEF}};
    wr_en      = 2'b11;
    wr_addr[0] = 4'd1;
    wr_data[0] = wide;
    wr_addr[1] = 4'd2;
    wr_data[1] = WIDTH'(32'h22);
    step();
    wr_en      = 2'b00;
    rd_addr[0] = 4'd1;
    rd_addr[1] = 4'd2;
    step();
    check("distinct_rd1", rd_data[0], wide);
    check("distinct_rd2", rd_data[1], WIDTH'(32'h22));

    // Same-edge read/write of addr 8 (old value 5)
    wr_en      = 2'b01;
    wr_addr[0] = 4'd8;
    wr_data[0] = WIDTH'(5);
    step();
    wr_data[0] = WIDTH'(32'hA);
    rd_addr[0] = 4'd8;
    rd_addr[1] = 4'd8;
`ifdef REGFILE_MP_BYPASS_EN
    exp8 = WIDTH'(32'hA);
`else
    exp8 = WIDTH'(5);
`endif
    step();
    wr_en = 2'b00;
    check("rw8_rd0", rd_data[0], exp8);
    check("rw8_rd1", rd_data[1], exp8);
    step();
    check("rw8_after", rd_data[0], WIDTH'(32'hA));

    // Reset mid-clear with write attempts throughout
    reset      = 1'b0;
    step();
    reset      = 1'b1;
    wr_en      = 2'b11;
    wr_addr[0] = 4'd9;
    wr_data[0] = WIDTH'(32'h99);
    wr_addr[1] = 4'd10;
    wr_data[1] = WIDTH'(32'h1010);
    for (int i = 0; i < 6; i++) begin
      step();
    end
    check("midclear_busy", WIDTH'(init_busy), WIDTH'(1));
    check("midclear_rd", rd_data[0], '0);
    reset = 1'b0;
    step();
    check("rerst_busy", WIDTH'(init_busy), WIDTH'(1));
    reset = 1'b1;
    count_clear(n);
    wr_en = 2'b00;
    check("reclear_edges", WIDTH'(n), WIDTH'(16));
    for (int i = 0; i < DEPTH; i += 2) begin
      rd_addr[0] = AW'(i);
      rd_addr[1] = AW'(i + 1);
      step();
      check("reclear_rd0", rd_data[0], '0);
      check("reclear_rd1", rd_data[1], '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
